dodawanie_sekw: RTL and testbench

- Multi-cycle parametrised adder/subtractor for the execution unit; successor to the single-cycle combinational adder.
- Processes WIDTH-bit operands in CHUNK-bit slices, LSB first, one slice per clock, with a start/busy/valid handshake.
- Trades latency for a short carry chain. Adds subtract mode and a signed-overflow flag.

---
 rtl/dodawanie_sekw.sv | 126 ++++++++++++
 tb/tb_dodawanie_sekw.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dodawanie_sekw.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are processed CHUNK bits per clock, LSB first.
// Optional accumulate mode (operand A taken from the last result) is enabled by DODAWANIE_SEKW_ACC_EN.
module dodawanie_sekw #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
`ifdef DODAWANIE_SEKW_ACC_EN
    input  logic             i_acc,
`endif
    input  logic [WIDTH-1:0] i_argA,
    input  logic [WIDTH-1:0] i_argB,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   carry;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [WIDTH-CHUNK-1:0] part;
    logic [WIDTH-CHUNK-1:0] part_next;
    logic [CHUNK:0]         slice_sum;
    logic                   msb_cin;
    logic [WIDTH-1:0]       a_load;
    logic [WIDTH-1:0]       b_load;
    logic                   accept;

    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Carry into the top bit of the slice, i.e. the carry into bit WIDTH-1 on the last slice.
    function automatic logic top_carry_in(input logic [CHUNK-1:0] a,
                                          input logic [CHUNK-1:0] b,
                                          input logic             cin);
        logic [CHUNK-1:0] low;
        low = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
        return low[CHUNK-1];
    endfunction

    always_comb begin
        slice_sum = slice_add(op_a[CHUNK-1:0], op_b[CHUNK-1:0], carry);
        msb_cin   = top_carry_in(op_a[CHUNK-1:0], op_b[CHUNK-1:0], carry);
        part_next = (part >> CHUNK)
                  | ((WIDTH-CHUNK)'(slice_sum[CHUNK-1:0]) << (WIDTH - 2*CHUNK));
    end

    always_comb begin
`ifdef DODAWANIE_SEKW_ACC_EN
        a_load = i_acc ? o_result : i_argA;
`else
        a_load = i_argA;
`endif
        b_load = i_sub ? ~i_argB : i_argB;
    end

    assign accept  = i_start && (state == IDLE || state == DONE);
    assign o_busy  = (state == RUN);
    assign o_valid = (state == DONE);

    // Control and architectural outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state <= RUN;
                        cnt   <= '0;
                        carry <= i_sub;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= slice_sum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_result   <= {slice_sum[CHUNK-1:0], part};
                        o_carry    <= slice_sum[CHUNK];
                        o_overflow <= slice_sum[CHUNK] ^ msb_cin;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shifters and partial result; slices leave at the bottom, sums enter at the top
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_a <= a_load;
            op_b <= b_load;
        end else if (state == RUN) begin
            op_a <= op_a >> CHUNK;
            op_b <= op_b >> CHUNK;
            part <= part_next;
        end
    end

endmodule

// File: tb/tb_dodawanie_sekw.sv
// Directed, table-driven bench for dodawanie_sekw (WIDTH=32, CHUNK=8) with hand-computed results.
module tb_dodawanie_sekw;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int STEPS = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic             acc;
    logic [WIDTH-1:0] arg_a;
    logic [WIDTH-1:0] arg_b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;

    always #5 clk = ~clk;

    dodawanie_sekw #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_sub      (sub),
`ifdef DODAWANIE_SEKW_ACC_EN
        .i_acc      (acc),
`endif
        .i_argA     (arg_a),
        .i_argB     (arg_b),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_result   (result),
        .o_carry    (carry),
        .o_overflow (overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        acc;
        int          gap;
        int          glitch;
        logic [31:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t        vecs[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] held_res = '0;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic s, logic ac,
                                int gap, int glitch, logic [31:0] res, logic c, logic v);
        vec_t t;
        t.a = a; t.b = b; t.sub = s; t.acc = ac; t.gap = gap; t.glitch = glitch;
        t.res = res; t.c = c; t.v = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic hs_ok;
        int   bad_step;
        repeat (v.gap) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        sub   = v.sub;
        acc   = v.acc;
        arg_a = v.a;
        arg_b = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        arg_a = 32'hA5A5_A5A5;
        arg_b = 32'h5A5A_5A5A;
        sub   = ~v.sub;
        acc   = 1'b0;
        hs_ok = (busy === 1'b1) && (valid === 1'b0) && (result === held_res);
        bad_step = hs_ok ? -1 : 0;
        for (int i = 1; i <= STEPS; i++) begin
            @(negedge clk);
            if (i == v.glitch) begin
                start = 1'b1;
                arg_a = 32'd100;
                arg_b = 32'd100;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < STEPS) begin
                if (!((busy === 1'b1) && (valid === 1'b0) && (result === held_res))) begin
                    if (bad_step < 0) bad_step = i;
                    hs_ok = 1'b0;
                end
            end else if (!((busy === 1'b0) && (valid === 1'b1))) begin
                if (bad_step < 0) bad_step = i;
                hs_ok = 1'b0;
            end
        end
        check($sformatf("vec%0d handshake(first bad step %0d)", idx, bad_step),
              64'(hs_ok), 64'd1);
        check($sformatf("vec%0d result", idx), 64'(result), 64'(v.res));
        check($sformatf("vec%0d carry", idx), 64'(carry), 64'(v.c));
        check($sformatf("vec%0d overflow", idx), 64'(overflow), 64'(v.v));
        held_res = v.res;
        if (v.glitch != 0) begin
            @(posedge clk);
            #1;
            check($sformatf("vec%0d no_queued_start busy,valid", idx),
                  64'({busy, valid}), 64'd0);
        end
    endtask

    initial begin
        int quiet_bad;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        acc   = 1'b0;
        arg_a = '0;
        arg_b = '0;

        vecs.push_back(mk(32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 0, 32'h8000_0000, 0, 1));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 32'h0000_0000, 1, 1));
        vecs.push_back(mk(32'd5,         32'd7,         1, 0, 2, 0, 32'hFFFF_FFFE, 0, 0));
        vecs.push_back(mk(32'd7,         32'd5,         1, 0, 1, 0, 32'h0000_0002, 1, 0));
        vecs.push_back(mk(32'd3,         32'd4,         0, 0, 1, 2, 32'd7,         0, 0));
        vecs.push_back(mk(32'h00FF_00FF, 32'h0001_0001, 0, 0, 1, 0, 32'h0100_0100, 0, 0));
        vecs.push_back(mk(32'd10,        32'd20,        0, 0, 0, 0, 32'd30,        0, 0));
`ifdef DODAWANIE_SEKW_ACC_EN
        vecs.push_back(mk(32'd10,        32'd0,         0, 0, 1, 0, 32'd10,        0, 0));
        vecs.push_back(mk(32'hDEAD_BEEF, 32'd5,         0, 1, 0, 0, 32'd15,        0, 0));
        vecs.push_back(mk(32'hDEAD_BEEF, 32'd20,        1, 1, 1, 0, 32'hFFFF_FFFB, 0, 0));
`endif
        vecs.push_back(mk(32'h8000_0000, 32'd1,         1, 0, 1, 0, 32'h7FFF_FFFF, 1, 1));

        #2;
        check("reset {busy,valid,result,carry,ovf}",
              64'({busy, valid, result, carry, overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset between the second and third processing edges of an operation
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        arg_a = 32'h1234_5678;
        arg_b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset {busy,valid,result,carry,ovf}",
              64'({busy, valid, result, carry, overflow}), 64'd0);
        held_res = '0;
        @(negedge clk);
        rst = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 2 * STEPS; i++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        check("after reset no busy/valid (bad cycles)", 64'(quiet_bad), 64'd0);
        run_vec(99, mk(32'd2, 32'd2, 0, 0, 0, 0, 32'd4, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
